// File: rtl/gesture_evt_pkg.sv
// Shared defaults, drop-counter constants and gesture channel indices for gesture_event_queue.
package gesture_evt_pkg;

  localparam int N_GEST_DEF      = 8;
  localparam int FIFO_DEPTH_DEF  = 4;
  localparam int HOLDOFF_CYC_DEF = 5_000_000;

  localparam int                DROP_W   = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  // Bit positions of the PAJ7620 gesture status word.
  typedef enum logic [2:0] {
    GEST_UP    = 3'd0,
    GEST_DOWN  = 3'd1,
    GEST_LEFT  = 3'd2,
    GEST_RIGHT = 3'd3,
    GEST_FWD   = 3'd4,
    GEST_BACK  = 3'd5,
    GEST_CW    = 3'd6,
    GEST_CCW   = 3'd7
  } gesture_e;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/gesture_evt_fifo.sv
// Show-ahead synchronous FIFO holding gesture indices; head entry is visible on o_data while not empty.
module gesture_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_level   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees the slot in the same cycle, so a full FIFO can accept a push alongside it.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/gesture_event_queue.sv
// Edge-detects gesture levels, holds simultaneous edges in a pending set and serialises them into an event FIFO.
// Optional per-channel hold-off lockout is compiled in with GEST_HOLDOFF_EN.
module gesture_event_queue
  import gesture_evt_pkg::*;
#(
  parameter int N_GEST      = N_GEST_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int HOLDOFF_CYC = HOLDOFF_CYC_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_GEST-1:0]             gest_in,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(N_GEST)-1:0]     evt_id,
  output logic [N_GEST-1:0]             evt_onehot,
  output logic [DROP_W-1:0]             drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int ID_W = $clog2(N_GEST);

  logic [N_GEST-1:0] r_gest_d;
  logic [N_GEST-1:0] r_pending;
  logic [DROP_W-1:0] r_drop_cnt;
  logic [N_GEST-1:0] w_lock;
  logic [N_GEST-1:0] w_edge;
  logic [N_GEST-1:0] w_push_mask;
  logic [N_GEST-1:0] w_merged;
  logic [ID_W-1:0]   w_push_id;
  logic [ID_W-1:0]   w_head_id;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [4:0]        w_merged_cnt;
  logic [DROP_W:0]   w_drop_sum;

  assign w_edge = gest_in & ~r_gest_d & ~w_lock;

  always_comb begin
    w_push_id = '0;
    for (int i = N_GEST - 1; i >= 0; i--) begin
      if (r_pending[i]) w_push_id = ID_W'(i);
    end
  end

  assign w_push      = !w_full && (|r_pending);
  assign w_push_mask = w_push ? (N_GEST'(1) << w_push_id) : '0;
  // A fresh edge on the bit being pushed is a new event, not a merge.
  assign w_merged    = w_edge & r_pending & ~w_push_mask;

  assign w_merged_cnt = popcount16(16'(w_merged));
  assign w_drop_sum   = {1'b0, r_drop_cnt} + (DROP_W+1)'(w_merged_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gest_d   <= '0;
      r_pending  <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_gest_d   <= gest_in;
      r_pending  <= (r_pending & ~w_push_mask) | w_edge;
      r_drop_cnt <= w_drop_sum[DROP_W] ? DROP_MAX : w_drop_sum[DROP_W-1:0];
    end
  end

`ifdef GEST_HOLDOFF_EN
  localparam int LOCK_W = $clog2(HOLDOFF_CYC + 1);

  logic [LOCK_W-1:0] r_lock_cnt [N_GEST];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_GEST; k++) r_lock_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < N_GEST; k++) begin
        if (w_edge[k])                r_lock_cnt[k] <= LOCK_W'(HOLDOFF_CYC);
        else if (r_lock_cnt[k] != '0) r_lock_cnt[k] <= r_lock_cnt[k] - 1'b1;
      end
    end
  end

  always_comb begin
    w_lock = '0;
    for (int k = 0; k < N_GEST; k++) w_lock[k] = |r_lock_cnt[k];
  end
`else
  assign w_lock = '0;
`endif

  gesture_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ID_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_id),
    .i_pop   (w_pop),
    .o_data  (w_head_id),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fifo_level)
  );

  // Handshake: the head event is transferred on any cycle with evt_valid && evt_ready; while evt_valid
  // is high and evt_ready low the head (evt_id/evt_onehot) holds, and evt_valid never drops without a pop.
  assign evt_valid  = !w_empty;
  assign w_pop      = evt_valid && evt_ready;
  assign evt_id     = evt_valid ? w_head_id : '0;
  assign evt_onehot = evt_valid ? (N_GEST'(1) << w_head_id) : '0;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_gesture_event_queue.sv
// Directed self-checking bench for gesture_event_queue; honours GEST_HOLDOFF_EN when it is defined.
module tb_gesture_event_queue;
  import gesture_evt_pkg::*;

  localparam int NG    = 8;
  localparam int DEPTH = 4;
  localparam int HOLD  = 10;
  localparam int IDW   = 3;
  localparam int GAP   = 12;

  logic            clk       = 1'b0;
  logic            rst       = 1'b1;
  logic [NG-1:0]   gest_in   = '0;
  logic            evt_ready = 1'b0;
  logic            evt_valid;
  logic [IDW-1:0]  evt_id;
  logic [NG-1:0]   evt_onehot;
  logic [7:0]      drop_cnt;
  logic [IDW:0]    fifo_level;

  logic [IDW-1:0]  exp_q[$];
  int              n_checks = 0;
  int              n_errors = 0;

  logic            simul_v  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [IDW-1:0]  simul_id [6] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd3, 3'd0};

  gesture_event_queue #(
    .N_GEST      (NG),
    .FIFO_DEPTH  (DEPTH),
    .HOLDOFF_CYC (HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .gest_in    (gest_in),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_id     (evt_id),
    .evt_onehot (evt_onehot),
    .drop_cnt   (drop_cnt),
    .fifo_level (fifo_level)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- checking ----
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---- driver helpers ----
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) next_cyc();
  endtask

  task automatic expect_ids(input logic [IDW-1:0] a, input logic [IDW-1:0] b,
                            input logic [IDW-1:0] c, input logic [IDW-1:0] d,
                            input logic [IDW-1:0] e, input int n);
    logic [IDW-1:0] v [5];
    v = '{a, b, c, d, e};
    for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_left"},  32'(exp_q.size()), 32'd0);
    chk({tag, "_level"}, 32'(fifo_level),   32'd0);
  endtask

  // ---- scoreboard: every accepted event must match the head of exp_q ----
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_evt_q_size", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [IDW-1:0] w;
        w = exp_q.pop_front();
        chk("evt_id",     32'(evt_id),     32'(w));
        chk("evt_onehot", 32'(evt_onehot), 32'(1) << w);
      end
    end
  end

  initial begin
    // ---- reset ----
    idle(2);
    @(negedge clk);
    chk("rst_valid",  32'(evt_valid),  32'd0);
    chk("rst_id",     32'(evt_id),     32'd0);
    chk("rst_onehot", 32'(evt_onehot), 32'd0);
    chk("rst_drop",   32'(drop_cnt),   32'd0);
    chk("rst_level",  32'(fifo_level), 32'd0);
    next_cyc();
    rst = 1'b0;
    idle(2);

    // ---- single edge: evt_valid only in cycle 2 ----
    evt_ready = 1'b1;
    exp_q.push_back(IDW'(GEST_LEFT));
    gest_in = 8'h04;
    @(negedge clk); chk("single_c0_valid", 32'(evt_valid), 32'd0);
    next_cyc();
    @(negedge clk); chk("single_c1_valid", 32'(evt_valid), 32'd0);
    next_cyc();
    @(negedge clk);
    chk("single_c2_valid",  32'(evt_valid),  32'd1);
    chk("single_c2_id",     32'(evt_id),     32'd2);
    chk("single_c2_onehot", 32'(evt_onehot), 32'h04);
    chk("single_c2_drop",   32'(drop_cnt),   32'd0);
    next_cyc();
    @(negedge clk); chk("single_c3_valid", 32'(evt_valid), 32'd0);
    gest_in = '0;
    idle(15);

    // ---- simultaneous edges 0x0B: ids 0,1,3 on cycles 2,3,4 ----
    expect_ids(3'd0, 3'd1, 3'd3, 3'd0, 3'd0, 3);
    gest_in = 8'h0B;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) next_cyc();
      @(negedge clk);
      chk($sformatf("simul_c%0d_valid", c), 32'(evt_valid), 32'(simul_v[c]));
      if (simul_v[c]) chk($sformatf("simul_c%0d_id", c), 32'(evt_id), 32'(simul_id[c]));
    end
    next_cyc();
    gest_in = '0;
    check_drained("simul");
    idle(15);

    // ---- hold-off: bit 0 rises at cycles 0, 4 and 12 ----
`ifdef GEST_HOLDOFF_EN
    expect_ids(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 2);
`else
    expect_ids(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3);
`endif
    for (int c = 0; c < 20; c++) begin
      gest_in = (c == 0 || c == 1 || c == 4 || c == 5 || c == 12 || c == 13) ? 8'h01 : 8'h00;
      next_cyc();
    end
    idle(5);
    check_drained("holdoff");
    chk("holdoff_drop", 32'(drop_cnt), 32'd0);
    idle(15);

    // ---- back-pressure: six edges 7..2, FIFO takes four, two wait pending ----
    evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      gest_in = gest_in | (8'h80 >> i);
      next_cyc();
    end
    @(negedge clk);
    chk("bp_level",   32'(fifo_level), 32'd4);
    chk("bp_drop",    32'(drop_cnt),   32'd0);
    chk("bp_valid",   32'(evt_valid),  32'd1);
    chk("bp_head_id", 32'(evt_id),     32'd7);
    next_cyc();
    @(negedge clk);
    chk("bp_hold_id",     32'(evt_id),     32'd7);
    chk("bp_hold_onehot", 32'(evt_onehot), 32'h80);
    expect_ids(3'd7, 3'd6, 3'd5, 3'd4, 3'd2, 5);
    exp_q.push_back(3'd3);
    next_cyc();
    evt_ready = 1'b1;
    idle(10);
    check_drained("bp");
    gest_in = '0;
    idle(15);

    // ---- merge: bit 5 rises twice while the FIFO is full ----
    evt_ready = 1'b0;
    gest_in = 8'h0F;
    idle(6);
    chk("merge_full_level", 32'(fifo_level), 32'd4);
    gest_in = 8'h2F; next_cyc();
    gest_in = 8'h0F; idle(GAP);
    gest_in = 8'h2F; next_cyc();
    gest_in = 8'h0F;
    @(negedge clk);
    chk("merge_drop", 32'(drop_cnt), 32'd1);
    expect_ids(3'd0, 3'd1, 3'd2, 3'd3, IDW'(GEST_BACK), 5);
    next_cyc();
    evt_ready = 1'b1;
    idle(10);
    check_drained("merge");
    gest_in = '0;
    idle(15);

    // ---- saturation: 300 further merges on bit 5 ----
    evt_ready = 1'b0;
    gest_in = 8'h0F;
    idle(6);
    gest_in = 8'h2F; next_cyc();
    gest_in = 8'h0F; idle(GAP);
    for (int i = 0; i < 300; i++) begin
      gest_in = 8'h2F; next_cyc();
      gest_in = 8'h0F; idle(GAP);
      if (i == 99) chk("sat_drop_101", 32'(drop_cnt), 32'd101);
    end
    chk("sat_drop_255", 32'(drop_cnt), 32'd255);
    expect_ids(3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 5);
    evt_ready = 1'b1;
    idle(10);
    check_drained("sat");
    gest_in = '0;
    idle(15);

    // ---- reset mid-operation with level 3 and bit 7 pending ----
    evt_ready = 1'b0;
    gest_in = 8'h07;
    idle(3);
    gest_in = 8'h87;
    next_cyc();
    @(negedge clk);
    chk("midrst_pre_level", 32'(fifo_level), 32'd3);
    rst = 1'b1;
    #1;
    chk("midrst_valid",  32'(evt_valid),  32'd0);
    chk("midrst_id",     32'(evt_id),     32'd0);
    chk("midrst_onehot", 32'(evt_onehot), 32'd0);
    chk("midrst_drop",   32'(drop_cnt),   32'd0);
    chk("midrst_level",  32'(fifo_level), 32'd0);
    exp_q.delete();
    idle(2);
    expect_ids(3'd0, 3'd1, 3'd2, 3'd7, 3'd0, 4);
    evt_ready = 1'b1;
    rst = 1'b0;
    idle(12);
    check_drained("midrst");
    chk("midrst_post_drop", 32'(drop_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
